// File: rtl/parallel_to_serial_rf.sv
// parallel_to_serial_rf: unpacks a word of N_ELEMS elements into a valid/ready element stream, lowest index first.
module parallel_to_serial_rf #(
    parameter int WIDTH   = 1,
    parameter int N_ELEMS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [N_ELEMS*WIDTH-1:0]   in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out,
    output logic                       out_last,
    output logic [31:0]                out_idx
);
    typedef enum logic {EMPTY, STREAM} state_t;
    state_t state, state_n;
    logic [N_ELEMS*WIDTH-1:0] data, data_n;
    logic [31:0] idx, idx_n;
    logic load, take;
    always_comb begin
        out_valid = state == STREAM;
        out       = out_valid ? data[idx*WIDTH +: WIDTH] : '0;
        out_last  = out_valid & (idx == 32'(N_ELEMS - 1));
        out_idx   = out_valid ? idx : '0;
        // the final take frees the word slot in the same cycle, so the next word loads bubble-free
        in_ready  = !rst & ((state == EMPTY) | (out_ready & out_last));
        load      = in_valid & in_ready;
        take      = out_valid & out_ready;
        state_n   = state;
        data_n    = data;
        idx_n     = idx;
        if (load) begin
            data_n  = in;
            idx_n   = '0;
            state_n = STREAM;
        end else if (take) begin
            state_n = out_last ? EMPTY : STREAM;
            idx_n   = out_last ? idx : idx + 32'd1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            idx   <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
        end
    end
    always_ff @(posedge clk) data <= data_n;
endmodule

// File: doc/parallel_to_serial_rf.md
# parallel_to_serial_rf

Converts one wide word of `N_ELEMS` packed elements into a stream of `WIDTH`-bit elements, one per output handshake, lowest-indexed element first. It is the transmit-side counterpart of `serial_to_parallel_rf`: a word produced by a unit with a wide datapath is unpacked here and handed to a unit that consumes one element per transfer. Both ports use valid/ready handshakes. The block sustains back-to-back words with no bubble between the last element of one word and the first element of the next.

## Interface
Parameters:
- `WIDTH`, 1, bit width of one element.
- `N_ELEMS`, 4, elements per input word; must be ≥ 1.

Ports:
- `clk`  input  1  clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  `in` holds a word to load.
- `in_ready`  output  1  block accepts a word this cycle.
- `in`  input  `N_ELEMS*WIDTH`  packed word; element k is `in[k*WIDTH +: WIDTH]`.
- `out_valid`  output  1  `out` holds a valid element.
- `out_ready`  input  1  consumer takes `out` this cycle.
- `out`  output  `WIDTH`  current element.
- `out_last`  output  1  current element is element `N_ELEMS-1` of its word.
- `out_idx`  output  32  index of the current element within its word.

## Operation
- Internal state: `state` ∈ {EMPTY, STREAM}, a word register `data` of width `N_ELEMS*WIDTH`, and a 32-bit index register `idx`.
- Handshake events:
  - Load: `in_valid & in_ready`.
  - Take: `out_valid & out_ready`.
- EMPTY:
  - `out_valid=0`, `in_ready=1`.
  - On a load: `data <= in`, `idx <= 0`, go to STREAM.
- STREAM:
  - `out_valid=1`, `out = data[idx*WIDTH +: WIDTH]`, `out_last = (idx == N_ELEMS-1)`, `out_idx = idx`.
  - Take with `out_last=0`: `idx <= idx+1`.
  - Take with `out_last=1` and a load in the same cycle: `data <= in`, `idx <= 0`, stay in STREAM.
  - Take with `out_last=1` and no load: go to EMPTY.
  - No take: hold all state; `out`, `out_last` and `out_idx` are stable.
- `in_ready = !rst & ((state==EMPTY) | (out_ready & out_last))`. This is a combinational path from `out_ready` to `in_ready`, and it is intended.
- A load while in STREAM is only possible on the final take, because `in_ready` is low at all other times in STREAM.
- When `out_valid=0`, the block drives `out=0`, `out_last=0` and `out_idx=0`.
- For `N_ELEMS=1`, `out_last` is 1 whenever `out_valid` is 1. Each word then yields exactly one element, and a new word may be loaded on every take.
- Indexing is 32-bit with unsigned compare. `idx` never exceeds `N_ELEMS-1`, so no wrap beyond that value is possible.

## Timing
- Reset (`rst=1` at an edge):
  - `state <= EMPTY`, `idx <= 0`.
  - Outputs after that edge: `out_valid=0`, `out=0`, `out_last=0`, `out_idx=0`, `in_ready=1` (once `rst` is deasserted).
  - `data` is not reset.
- `in_ready` is forced to 0 during any cycle in which `rst=1`. Reset takes priority over a simultaneous load or take.
- Reset in the middle of a word discards the remaining elements. No `out_last` is produced for the discarded word.
- Latency: a word loaded at edge T presents element 0 with `out_valid=1` in the cycle after T. With no backpressure the word occupies `N_ELEMS` consecutive cycles.
- Throughput: with `in_valid` and `out_ready` held high, the block produces one element per cycle continuously and has zero idle cycles between words.
- Backpressure: if `out_ready=0` for k cycles, the word's completion is delayed by exactly k cycles. The element order is unchanged.
- `in` only needs to be stable in the cycle of the load. The block never samples it again.

## Test plan
All scenarios use `WIDTH=8`, `N_ELEMS=4` unless stated otherwise.
- Single word: load 0x44332211 at edge T with `out_ready=1` → `out` = 0x11, 0x22, 0x33, 0x44 in cycles T+1..T+4; `out_idx` = 0..3; `out_last=1` only in T+4; `out_valid=0` from T+5 onward.
- Back-to-back: words 0x44332211 and 0x88776655 offered with `in_valid` held high and `out_ready=1` → eight consecutive elements 0x11..0x88 with no gap; `in_ready=1` only in the EMPTY cycle and in the two `out_last` cycles.
- Backpressure: load 0xDDCCBBAA, then drive `out_ready=0` while 0xBB is presented for 3 cycles → 0xBB is held stable for 3 cycles with `out_idx=1`; `in_ready=0` throughout; 0xCC and 0xDD follow; total 7 cycles from the first `out_valid`.
- Reset mid-word: assert `rst` for 1 cycle after 0x22 is taken from 0x44332211 → the next cycle shows `out_valid=0` and `in_ready=1`; a new word 0x0D0C0B0A then emits 0x0A first with `out_idx=0`.
- `N_ELEMS=1`: continuous words 0x5A, 0xA5, 0x3C with `out_ready=1` → one element per cycle; `out_last=1` on every element; `in_ready` follows `out_ready` while streaming.
- Round trip: connect the block's output to `serial_to_parallel_rf` (`N_OUTS=4`, `en` = take), send 16 random words → every reassembled word equals the word sent.
